// File: rtl/shared_mem_if.sv
// Command/response bundle between two requesters (A, B) and shared_mem_arbiter.
// A command transfers on a cycle where valid and ready are both high; ready never waits on a later valid.
interface shared_mem_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          a_valid;
  logic          a_ready;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_rsp_valid;
  logic [DW-1:0] a_rsp_data;

  logic          b_valid;
  logic          b_ready;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_rsp_valid;
  logic [DW-1:0] b_rsp_data;

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  a_ready, a_rsp_valid, a_rsp_data,
    input  b_ready, b_rsp_valid, b_rsp_data
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output a_ready, a_rsp_valid, a_rsp_data,
    output b_ready, b_rsp_valid, b_rsp_data
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising two requesters onto a 2**AW x DW register array.
// IDLE grants one command, EXEC touches the array, RESP pulses the owner's response.
module shared_mem_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  shared_mem_if.slave bus,
  output logic       busy,
  output logic [7:0] xact_cnt,
  output logic [1:0] state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  localparam int DEPTH = 1 << AW;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;    // 0 = A wins a tie, 1 = B wins a tie
  logic          owner_q, owner_d;  // 0 = A, 1 = B
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          a_rsp_valid_q, a_rsp_valid_d;
  logic          b_rsp_valid_q, b_rsp_valid_d;
  logic [DW-1:0] a_rsp_data_q, a_rsp_data_d;
  logic [DW-1:0] b_rsp_data_q, b_rsp_data_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          grant_a, grant_b;
  logic [DW-1:0] rsp_w;

  always_comb begin
    grant_a       = (state_q == IDLE) && bus.a_valid && (!bus.b_valid || !prio_q);
    grant_b       = (state_q == IDLE) && bus.b_valid && (!bus.a_valid || prio_q);
    state_d       = state_q;
    prio_d        = prio_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mem_d         = mem_q;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    a_rsp_data_d  = a_rsp_data_q;
    b_rsp_data_d  = b_rsp_data_q;
    cnt_d         = cnt_q;
    rsp_w         = we_q ? wdata_q : mem_q[addr_q];

    case (state_q)
      IDLE: begin
        if (grant_a) begin
          owner_d = 1'b0;
          we_d    = bus.a_we;
          addr_d  = bus.a_addr;
          wdata_d = bus.a_wdata;
          prio_d  = 1'b1;
          state_d = EXEC;
        end else if (grant_b) begin
          owner_d = 1'b1;
          we_d    = bus.b_we;
          addr_d  = bus.b_addr;
          wdata_d = bus.b_wdata;
          prio_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Response registers load here so the pulse and count are visible during RESP.
        if (we_q) mem_d[addr_q] = wdata_q;
        if (owner_q) begin
          b_rsp_valid_d = 1'b1;
          b_rsp_data_d  = rsp_w;
        end else begin
          a_rsp_valid_d = 1'b1;
          a_rsp_data_d  = rsp_w;
        end
        cnt_d   = cnt_q + 8'd1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mem_q         <= '{default: '0};
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mem_q         <= mem_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_data_q  <= b_rsp_data_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.a_rsp_data  = a_rsp_data_q;
  assign bus.b_rsp_data  = b_rsp_data_q;
  assign busy            = (state_q != IDLE);
  assign xact_cnt        = cnt_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: a vector table of single transactions plus
// hand-written tie, ordering, counter-wrap and mid-operation reset sequences.
module tb_shared_mem_arbiter;
  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] xact_cnt;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  shared_mem_if #(.DW(8), .AW(4)) bus ();

  shared_mem_arbiter #(.DW(8), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .xact_cnt  (xact_cnt),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         is_b;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_valid = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_state"},   state_dbg, 0);
    chk({tag, "_cnt"},     xact_cnt, 0);
    chk({tag, "_a_rspv"},  bus.a_rsp_valid, 0);
    chk({tag, "_b_rspv"},  bus.b_rsp_valid, 0);
    chk({tag, "_a_rspd"},  bus.a_rsp_data, 0);
    chk({tag, "_b_rspd"},  bus.b_rsp_data, 0);
    chk({tag, "_ready"},   {bus.a_ready, bus.b_ready}, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    #1 check_cleared("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drivers: one command from one requester, checking latency and response routing.
  task automatic do_xact(input bit is_b, input bit we, input logic [3:0] addr,
                         input logic [7:0] wdata, output logic [7:0] rdata,
                         output logic [7:0] cnt);
    bit got;
    got = 1'b0;
    rdata = '0;
    cnt = '0;
    @(negedge clk);
    if (is_b) begin
      bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_valid = 1'b1;
    end else begin
      bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata; bus.a_valid = 1'b1;
    end
    #1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (is_b ? bus.b_ready : bus.a_ready) got = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    chk("grant_seen", got, 1);
    if (got) begin
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      #1;
      chk("exec_busy", busy, 1);
      chk("exec_no_rsp", {bus.a_rsp_valid, bus.b_rsp_valid}, 0);
      @(negedge clk);
      #1;
      chk("rsp_route", {bus.a_rsp_valid, bus.b_rsp_valid}, is_b ? 2'b01 : 2'b10);
      rdata = is_b ? bus.b_rsp_data : bus.a_rsp_data;
      cnt = xact_cnt;
    end else begin
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
    end
  endtask

  // Both requesters hold valid until n responses have come back; grants must alternate from A.
  task automatic run_tie(input int n, input bit a_we, input logic [7:0] a_wdata,
                         input logic [3:0] a_addr, input logic [3:0] b_addr,
                         input logic [7:0] exp_a, input logic [7:0] exp_b);
    bit pend[$];
    bit own;
    int grants, rsps, cyc;
    grants = 0; rsps = 0; cyc = 0;
    @(negedge clk);
    bus.a_we = a_we; bus.a_addr = a_addr; bus.a_wdata = a_wdata; bus.a_valid = 1'b1;
    bus.b_we = 1'b0; bus.b_addr = b_addr; bus.b_wdata = '0;      bus.b_valid = 1'b1;
    #1;
    while (rsps < n && cyc < 10 * n) begin
      chk("tie_ready_excl", bus.a_ready & bus.b_ready, 0);
      if (bus.a_ready || bus.b_ready) begin
        chk("tie_order", bus.b_ready, grants % 2);
        pend.push_back(bus.b_ready);
        grants++;
      end
      if (bus.a_rsp_valid || bus.b_rsp_valid) begin
        own = (pend.size() > 0) ? pend.pop_front() : 1'b0;
        chk("tie_rsp_route", {bus.a_rsp_valid, bus.b_rsp_valid}, own ? 2'b01 : 2'b10);
        if (own) chk("tie_b_data", bus.b_rsp_data, exp_b);
        else     chk("tie_a_data", bus.a_rsp_data, exp_a);
        rsps++;
      end
      if (rsps < n) begin
        @(negedge clk);
        #1;
        cyc++;
      end
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    chk("tie_done", rsps, n);
  endtask

  // Reset asserted in the EXEC cycle of a write; the command must vanish without a response.
  task automatic reset_mid_write(input bit is_b, input logic [3:0] addr, input logic [7:0] wdata);
    bit got, seen;
    got = 1'b0; seen = 1'b0;
    @(negedge clk);
    if (is_b) begin
      bus.b_we = 1'b1; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_valid = 1'b1;
    end else begin
      bus.a_we = 1'b1; bus.a_addr = addr; bus.a_wdata = wdata; bus.a_valid = 1'b1;
    end
    #1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (is_b ? bus.b_ready : bus.a_ready) got = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    chk("mid_grant_seen", got, 1);
    @(negedge clk);
    idle_inputs();
    #1 chk("mid_exec_state", state_dbg, 1);
    rst_n = 1'b0;
    #1 check_cleared("mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 if (bus.a_rsp_valid || bus.b_rsp_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", seen, 0);
    chk("mid_idle", state_dbg, 0);
    run_tie(2, 1'b0, 8'h00, addr, addr, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] rd, cnt, exp;

    vecs[0] = '{1'b1, 1'b0, 4'd9,  8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 4'd3,  8'h5A, 8'h5A};
    vecs[2] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'h5A};
    vecs[3] = '{1'b1, 1'b1, 4'd0,  8'hFF, 8'hFF};
    vecs[4] = '{1'b0, 1'b0, 4'd0,  8'h00, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 4'd15, 8'h00, 8'hC3};
    vecs[6] = '{1'b0, 1'b1, 4'd15, 8'h01, 8'h01};
    vecs[7] = '{1'b1, 1'b1, 4'd15, 8'h02, 8'h02};
    vecs[8] = '{1'b0, 1'b0, 4'd15, 8'h00, 8'h02};
    vecs[9] = '{1'b1, 1'b0, 4'd3,  8'h00, 8'h5A};

    rst_n = 1'b0;
    idle_inputs();
    apply_reset();

    // Tie straight out of reset: A, B, A, B; reset memory reads back as zero.
    run_tie(4, 1'b0, 8'h00, 4'd3, 4'd9, 8'h00, 8'h00);
    chk("tie_cnt", xact_cnt, 4);

    // A writes 0xC3 to 15 while B reads 15 in the same cycle: A first, B sees new data.
    run_tie(2, 1'b1, 8'hC3, 4'd15, 4'd15, 8'hC3, 8'hC3);

    // Vector table; the counter continues from 6.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].exp);
      do_xact(vecs[i].is_b, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, cnt);
      exp = exp_q.pop_front();
      chk($sformatf("vec%0d_data", i), rd, exp);
      chk($sformatf("vec%0d_cnt", i), cnt, 7 + i);
    end

    // Counter wrap from a fresh reset.
    apply_reset();
    for (int i = 1; i <= 257; i++) begin
      do_xact(1'b0, 1'b1, i[3:0], i[7:0], rd, cnt);
      if (i == 255) begin
        chk("wrap255_cnt", cnt, 8'hFF);
        chk("wrap255_data", rd, 8'hFF);
      end
      if (i == 256) begin
        chk("wrap256_cnt", cnt, 8'h00);
        chk("wrap256_data", rd, 8'h00);
      end
      if (i == 257) chk("wrap257_cnt", cnt, 8'h01);
    end

    reset_mid_write(1'b1, 4'd7, 8'h77);
    reset_mid_write(1'b0, 4'd5, 8'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
